serial_port: RTL and testbench
==============================

Name: serial_port

Overview:
- Memory-mapped serial peripheral on the far side of the data memory's serial bus.
- Receives 8N1 UART frames and queues the bytes in an RX FIFO. The processor sees them through serial_valid_out/serial_out and pops them with serial_rden_in.
- Accepts bytes pushed with serial_wren_in into a TX FIFO and shifts them out as 8N1 frames.
- Sits at top level between the datapath's serial_* ports and the board UART pins.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200). Minimum 4; an even value is required.
- FIFO_DEPTH, 16, entries per FIFO. Must be a power of 2, minimum 2.

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- serial_in  input  8  byte to transmit (from the datapath's serial_out).
- serial_wren_in  input  1  push serial_in into the TX FIFO.
- serial_ready_out  output  1  TX FIFO not full.
- serial_out  output  8  head of the RX FIFO (first-word fall-through).
- serial_valid_out  output  1  RX FIFO not empty.
- serial_rden_in  input  1  pop the RX FIFO head.
- uart_rx_in  input  1  asynchronous UART receive line.
- uart_tx_out  output  1  UART transmit line; idles high.
- rx_overrun_out  output  1  sticky: a received byte was dropped because the RX FIFO was full.
- rx_frame_err_out  output  1  sticky: a stop bit was sampled as 0.
- tx_overflow_out  output  1  sticky: serial_wren_in arrived while the TX FIFO was full.

Behaviour:
- Reset
  - Outputs: uart_tx_out=1, serial_valid_out=0, serial_ready_out=1, serial_out=0, all sticky flags=0.
  - Both FIFOs are emptied and both FSMs go to IDLE. The rx synchronizer is preset to 1.
  - Reset mid-frame aborts the frame immediately. uart_tx_out returns to 1 the next cycle.
  - Sticky flags are cleared only by reset.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
- FIFO rules
  - Push and pop in the same cycle are both accepted even when the FIFO is full or empty-with-push; occupancy is then unchanged.
  - Pop of an empty FIFO is ignored; outputs do not change.
  - Push to a full FIFO without a simultaneous pop is dropped.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy is tracked with one extra count bit.
- TX path
  - serial_wren_in with the FIFO full and no pop that cycle: the byte is dropped and tx_overflow_out is set.
  - FSM states: TX_IDLE -> TX_START -> TX_DATA -> TX_STOP -> TX_IDLE.
  - In TX_IDLE with the FIFO not empty: pop a byte into the shift register and enter TX_START.
  - Each state holds for CLKS_PER_BIT cycles. TX_DATA runs 8 bits via a 3-bit index.
  - At the end of TX_STOP: pop the next byte if one is available and go straight to TX_START (back-to-back frames, no idle gap). Otherwise return to TX_IDLE.
  - uart_tx_out is registered.
  - Latency: wren accepted on edge N -> FIFO not empty after N -> pop on edge N+1 -> uart_tx_out=0 from edge N+2.
- RX path
  - uart_rx_in passes through a 2-flop synchronizer.
  - FSM states: RX_IDLE -> RX_START -> RX_DATA -> RX_STOP -> RX_IDLE.
  - RX_IDLE: a synchronized 0 enters RX_START with counter=0.
  - RX_START: at CLKS_PER_BIT/2, re-sample. If 1, treat as a glitch and return to RX_IDLE. If 0, enter RX_DATA.
  - RX_DATA: sample every CLKS_PER_BIT cycles (mid-bit) and shift in LSB first.
  - RX_STOP: one CLKS_PER_BIT after the last data sample, sample the stop bit.
    - Stop=1 and FIFO has room (or rden pops in the same cycle): push the byte.
    - Stop=1 and FIFO full with no pop: drop the byte and set rx_overrun_out.
    - Stop=0: discard the byte, set rx_frame_err_out, and wait in RX_STOP until the line reads 1 before returning to RX_IDLE.
  - On a good stop bit, return to RX_IDLE immediately.
  - serial_valid_out rises the cycle after the stop-bit sample edge.
- Counters
  - Bit counter width is clog2(CLKS_PER_BIT). It resets to 0 at every state transition.

Decomposition:
- Shared package serial_pkg holds:
  - TX/RX state encodings (2-bit localparams).
  - UART_DATA_BITS=8, START_BIT=1'b0, STOP_BIT=1'b1.
- One sub-module, sync_fifo (parameters W, DEPTH), instantiated twice: W=8 for RX and for TX.
  - Signals: push, pop, din, dout (FWFT), empty, full.
- The TX and RX FSMs stay inline in serial_port.

Test Plan:
- All scenarios use CLKS_PER_BIT=4, FIFO_DEPTH=4.
- Reset: assert reset for 2 cycles -> uart_tx_out=1, serial_ready_out=1, serial_valid_out=0, all flags 0.
- TX single byte: wren with serial_in=8'hA5 -> uart_tx_out=0 starting 2 edges later. The line then shows bits 1,0,1,0,0,1,0,1 (LSB first), each held 4 cycles, then stop=1. Total frame 40 cycles.
- TX overflow: 5 wrens of 8'h01..8'h05 in consecutive cycles while the TX FSM is busy -> serial_ready_out=0 once 4 bytes are queued and tx_overflow_out=1. The frames transmitted contain only the non-dropped bytes, in order.
- RX loopback: drive 8'h3C as an 8N1 frame on uart_rx_in -> serial_valid_out=1 with serial_out=8'h3C. Then rden -> serial_valid_out=0 the next cycle.
- RX glitch/framing: a 1-cycle low pulse -> no byte and no flag. A frame carrying 8'hFF with stop=0 -> no byte and rx_frame_err_out=1.
- RX overrun: 5 frames 8'h10..8'h14 with no rden -> FIFO holds 8'h10..8'h13 and rx_overrun_out=1. Four rdens return 8'h10..8'h13 in order.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared constants and FSM state encodings for the serial_port peripheral.
package serial_pkg;

  localparam int   UART_DATA_BITS = 8;
  localparam logic START_BIT      = 1'b0;
  localparam logic STOP_BIT       = 1'b1;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/serial_port_if.sv
// Processor-side byte interface of serial_port: TX push and RX first-word fall-through pop.
interface serial_port_if;
  logic [7:0] serial_in;
  logic       serial_wren_in;
  logic       serial_ready_out;
  logic [7:0] serial_out;
  logic       serial_valid_out;
  logic       serial_rden_in;

  modport master (
    output serial_in, serial_wren_in, serial_rden_in,
    input  serial_ready_out, serial_out, serial_valid_out
  );

  modport slave (
    input  serial_in, serial_wren_in, serial_rden_in,
    output serial_ready_out, serial_out, serial_valid_out
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous first-word fall-through FIFO; pointers carry one extra wrap bit
// so full and empty are distinguishable without a separate counter.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_push_ok;
  logic         w_pop_ok;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // a simultaneous pop frees the slot a full-FIFO push needs, and vice versa
  assign w_push_ok = push && (!full || pop);
  assign w_pop_ok  = pop && (!empty || push);
  assign dout      = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr[AW-1:0]] <= din;
        r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (w_pop_ok) r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end
endmodule

// File: rtl/serial_port.sv
// 8N1 UART peripheral: TX FIFO feeding a frame shifter, RX sampler feeding an RX FIFO,
// plus sticky overrun / framing / overflow error flags.
module serial_port
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic         clock,
  input  logic         reset,
  serial_port_if.slave bus,
  input  logic         uart_rx_in,
  output logic         uart_tx_out,
  output logic         rx_overrun_out,
  output logic         rx_frame_err_out,
  output logic         tx_overflow_out
);
  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic [7:0] w_tx_dout;
  logic       w_tx_empty;
  logic       w_tx_full;
  logic       w_tx_pop;
  logic [7:0] w_rx_dout;
  logic       w_rx_empty;
  logic       w_rx_full;
  logic       w_rx_push;

  sync_fifo #(.W(UART_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock(clock), .reset(reset),
    .push(bus.serial_wren_in), .pop(w_tx_pop), .din(bus.serial_in),
    .dout(w_tx_dout), .empty(w_tx_empty), .full(w_tx_full)
  );

  logic [7:0] r_rx_shift;

  sync_fifo #(.W(UART_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock(clock), .reset(reset),
    .push(w_rx_push), .pop(bus.serial_rden_in), .din(r_rx_shift),
    .dout(w_rx_dout), .empty(w_rx_empty), .full(w_rx_full)
  );

  assign bus.serial_ready_out = !w_tx_full;
  assign bus.serial_valid_out = !w_rx_empty;
  assign bus.serial_out       = w_rx_dout;

  tx_state_t     r_tx_state, w_tx_state_nxt;
  logic [CW-1:0] r_tx_cnt, w_tx_cnt_nxt;
  logic [2:0]    r_tx_idx, w_tx_idx_nxt;
  logic [7:0]    r_tx_shift;
  logic          r_tx_line, w_tx_line_nxt;
  logic          r_tx_ovf;

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt + CW'(1);
    w_tx_idx_nxt   = r_tx_idx;
    w_tx_pop       = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_cnt_nxt = '0;
        if (!w_tx_empty) begin
          w_tx_pop       = 1'b1;
          w_tx_state_nxt = TX_START;
        end
      end
      TX_START: begin
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_cnt_nxt   = '0;
          w_tx_idx_nxt   = 3'd0;
          w_tx_state_nxt = TX_DATA;
        end
      end
      TX_DATA: begin
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_cnt_nxt = '0;
          if (r_tx_idx == 3'd7) w_tx_state_nxt = TX_STOP;
          else                  w_tx_idx_nxt   = r_tx_idx + 3'd1;
        end
      end
      TX_STOP: begin
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_cnt_nxt = '0;
          // chain the next queued byte with no idle gap between frames
          if (!w_tx_empty) begin
            w_tx_pop       = 1'b1;
            w_tx_state_nxt = TX_START;
          end else begin
            w_tx_state_nxt = TX_IDLE;
          end
        end
      end
      default: begin
        w_tx_cnt_nxt   = '0;
        w_tx_state_nxt = TX_IDLE;
      end
    endcase
    case (r_tx_state)
      TX_START: w_tx_line_nxt = START_BIT;
      TX_DATA:  w_tx_line_nxt = r_tx_shift[r_tx_idx];
      TX_STOP:  w_tx_line_nxt = STOP_BIT;
      default:  w_tx_line_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= 3'd0;
      r_tx_shift <= 8'h00;
      r_tx_line  <= 1'b1;
      r_tx_ovf   <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_idx   <= w_tx_idx_nxt;
      r_tx_line  <= w_tx_line_nxt;
      if (w_tx_pop) r_tx_shift <= w_tx_dout;
      if (bus.serial_wren_in && w_tx_full && !w_tx_pop) r_tx_ovf <= 1'b1;
    end
  end

  rx_state_t     r_rx_state, w_rx_state_nxt;
  logic [CW-1:0] r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0]    r_rx_idx, w_rx_idx_nxt;
  logic [7:0]    w_rx_shift_nxt;
  logic          r_rx_meta, r_rx_sync;
  logic          r_rx_wait, w_rx_wait_nxt;
  logic          r_rx_ovr, r_rx_ferr;
  logic          w_rx_ovr_set, w_rx_ferr_set;

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt + CW'(1);
    w_rx_idx_nxt   = r_rx_idx;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_wait_nxt  = r_rx_wait;
    w_rx_push      = 1'b0;
    w_rx_ovr_set   = 1'b0;
    w_rx_ferr_set  = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        w_rx_cnt_nxt = '0;
        if (r_rx_sync == START_BIT) w_rx_state_nxt = RX_START;
      end
      RX_START: begin
        // counting starts on the detect cycle, so HALF_LAST lands mid start bit
        if (r_rx_cnt == HALF_LAST) begin
          w_rx_cnt_nxt = '0;
          w_rx_idx_nxt = 3'd0;
          if (r_rx_sync == START_BIT) w_rx_state_nxt = RX_DATA;
          else                        w_rx_state_nxt = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (r_rx_cnt == BIT_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_shift_nxt = {r_rx_sync, r_rx_shift[7:1]};
          if (r_rx_idx == 3'd7) w_rx_state_nxt = RX_STOP;
          else                  w_rx_idx_nxt   = r_rx_idx + 3'd1;
        end
      end
      RX_STOP: begin
        if (r_rx_wait) begin
          w_rx_cnt_nxt = '0;
          if (r_rx_sync == STOP_BIT) begin
            w_rx_wait_nxt  = 1'b0;
            w_rx_state_nxt = RX_IDLE;
          end
        end else if (r_rx_cnt == BIT_LAST) begin
          w_rx_cnt_nxt = '0;
          if (r_rx_sync == STOP_BIT) begin
            w_rx_state_nxt = RX_IDLE;
            if (!w_rx_full || bus.serial_rden_in) w_rx_push    = 1'b1;
            else                                  w_rx_ovr_set = 1'b1;
          end else begin
            w_rx_ferr_set = 1'b1;
            w_rx_wait_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_rx_cnt_nxt   = '0;
        w_rx_wait_nxt  = 1'b0;
        w_rx_state_nxt = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_idx   <= 3'd0;
      r_rx_shift <= 8'h00;
      r_rx_wait  <= 1'b0;
      r_rx_ovr   <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_meta  <= uart_rx_in;
      r_rx_sync  <= r_rx_meta;
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_idx   <= w_rx_idx_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_rx_wait  <= w_rx_wait_nxt;
      if (w_rx_ovr_set)  r_rx_ovr  <= 1'b1;
      if (w_rx_ferr_set) r_rx_ferr <= 1'b1;
    end
  end

  assign uart_tx_out      = r_tx_line;
  assign tx_overflow_out  = r_tx_ovf;
  assign rx_overrun_out   = r_rx_ovr;
  assign rx_frame_err_out = r_rx_ferr;
endmodule

// File: tb/tb_serial_port.sv
// Bench for serial_port: directed and table-driven RX frames, randomized TX/RX traffic
// scored against queue models, and a line decoder that rebuilds transmitted bytes.
module tb_serial_port;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  logic rx;
  logic tx, ovr, ferr, txo;

  serial_port_if u_bus();

  serial_port #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clk), .reset(reset), .bus(u_bus), .uart_rx_in(rx),
    .uart_tx_out(tx), .rx_overrun_out(ovr), .rx_frame_err_out(ferr),
    .tx_overflow_out(txo)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] rxm_q[$];
  logic m_ovr = 1'b0, m_ferr = 1'b0, m_txo = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       stop_b;
    logic       exp_valid;
    logic       exp_ferr;
  } rx_vec_t;
  rx_vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    logic [9:0] bits;
    bits = {stop_b, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (CPB) tick();
    end
    rx = 1'b1;
  endtask

  task automatic pop_rx();
    u_bus.serial_rden_in = 1'b1;
    tick();
    u_bus.serial_rden_in = 1'b0;
  endtask

  task automatic push_tx(input logic [7:0] d);
    u_bus.serial_in      = d;
    u_bus.serial_wren_in = 1'b1;
    tick();
    u_bus.serial_wren_in = 1'b0;
  endtask

  task automatic compare_tx();
    check("tx_frame_count", got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      check("tx_frame_data", got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  // Decodes frames on uart_tx_out by sampling one cycle into each bit period.
  initial begin : tx_monitor
    logic prev, stopv, aborted;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && prev === 1'b1 && tx === 1'b0) begin
        aborted = 1'b0;
        b       = 8'h00;
        stopv   = 1'b0;
        for (int k = 1; k <= 37; k++) begin
          @(negedge clk);
          if (reset !== 1'b0) aborted = 1'b1;
          if (k >= 5 && k <= 33 && (k % 4) == 1) b[(k - 5) / 4] = tx;
          if (k == 37) stopv = tx;
        end
        if (!aborted) begin
          check("tx_stop_bit", {31'd0, stopv}, 32'd1);
          got_q.push_back(b);
        end
      end
      prev = tx;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0] frame;
    int n;
    logic [7:0] d;

    vecs[0] = '{data: 8'h3C, stop_b: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};
    vecs[1] = '{data: 8'hFF, stop_b: 1'b0, exp_valid: 1'b0, exp_ferr: 1'b1};
    vecs[2] = '{data: 8'h00, stop_b: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b1};
    vecs[3] = '{data: 8'hA5, stop_b: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b1};
    vecs[4] = '{data: 8'h81, stop_b: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b1};

    reset                = 1'b1;
    rx                   = 1'b1;
    u_bus.serial_in      = 8'h00;
    u_bus.serial_wren_in = 1'b0;
    u_bus.serial_rden_in = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    check("reset_tx_line", {31'd0, tx}, 32'd1);
    check("reset_ready", {31'd0, u_bus.serial_ready_out}, 32'd1);
    check("reset_valid", {31'd0, u_bus.serial_valid_out}, 32'd0);
    check("reset_serial_out", {24'd0, u_bus.serial_out}, 32'd0);
    check("reset_flags", {29'd0, ovr, ferr, txo}, 32'd0);

    // single byte: exact cycle-by-cycle line shape
    push_tx(8'hA5);
    exp_q.push_back(8'hA5);
    tick();
    check("tx_pre_start", {31'd0, tx}, 32'd1);
    frame = {1'b1, 8'hA5, 1'b0};
    for (int c = 0; c < 40; c++) begin
      tick();
      check("tx_a5_line", {31'd0, tx}, {31'd0, frame[c / 4]});
    end
    tick();
    check("tx_after_frame", {31'd0, tx}, 32'd1);
    repeat (4) tick();
    compare_tx();

    // overflow while the transmitter is busy
    push_tx(8'hEE);
    exp_q.push_back(8'hEE);
    repeat (3) tick();
    for (int i = 1; i <= 5; i++) begin
      push_tx(8'(i));
      if (i <= DEPTH) exp_q.push_back(8'(i));
    end
    m_txo = 1'b1;
    check("tx_ready_full", {31'd0, u_bus.serial_ready_out}, 32'd0);
    check("tx_overflow", {31'd0, txo}, 32'd1);
    repeat (5 * 40 + 10) tick();
    compare_tx();

    // random bursts from idle: transmitter takes one byte, FIFO holds DEPTH more
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) begin
        d = 8'($urandom);
        push_tx(d);
        if (i < DEPTH + 1) exp_q.push_back(d);
      end
      if (n > DEPTH + 1) m_txo = 1'b1;
      check("tx_rand_ready", {31'd0, u_bus.serial_ready_out}, {31'd0, (n <= DEPTH)});
      repeat (((n < DEPTH + 1) ? n : DEPTH + 1) * 40 + 10) tick();
      compare_tx();
      check("tx_rand_overflow", {31'd0, txo}, {31'd0, m_txo});
    end

    // reset mid-frame aborts the transmission
    push_tx(8'h5A);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    check("tx_reset_abort_line", {31'd0, tx}, 32'd1);
    reset = 1'b0;
    m_txo = 1'b0;
    check("tx_reset_clears_flag", {31'd0, txo}, 32'd0);
    repeat (45) tick();
    check("tx_reset_no_frame", got_q.size(), 32'd0);
    got_q.delete();

    // glitch: one-cycle low pulse is not a start bit
    rx = 1'b0;
    tick();
    rx = 1'b1;
    repeat (10) tick();
    check("rx_glitch_valid", {31'd0, u_bus.serial_valid_out}, 32'd0);
    check("rx_glitch_flags", {30'd0, ovr, ferr}, 32'd0);

    // table-driven receive frames
    for (int v = 0; v < 5; v++) begin
      send_frame(vecs[v].data, vecs[v].stop_b);
      repeat (4) tick();
      check("rx_tbl_valid", {31'd0, u_bus.serial_valid_out}, {31'd0, vecs[v].exp_valid});
      check("rx_tbl_ferr", {31'd0, ferr}, {31'd0, vecs[v].exp_ferr});
      if (vecs[v].exp_valid) begin
        check("rx_tbl_data", {24'd0, u_bus.serial_out}, {24'd0, vecs[v].data});
        pop_rx();
        check("rx_tbl_pop_valid", {31'd0, u_bus.serial_valid_out}, 32'd0);
      end
    end
    m_ferr = 1'b1;

    // random receive bursts against a queue model
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        d = 8'($urandom);
        send_frame(d, 1'b1);
        if (rxm_q.size() < DEPTH) rxm_q.push_back(d);
        else                      m_ovr = 1'b1;
      end
      repeat (4) tick();
      check("rx_rand_overrun", {31'd0, ovr}, {31'd0, m_ovr});
      while (rxm_q.size() > 0) begin
        check("rx_rand_valid", {31'd0, u_bus.serial_valid_out}, 32'd1);
        check("rx_rand_data", {24'd0, u_bus.serial_out}, {24'd0, rxm_q.pop_front()});
        pop_rx();
      end
      check("rx_rand_empty", {31'd0, u_bus.serial_valid_out}, 32'd0);
      pop_rx();
      check("rx_pop_empty_ignored", {31'd0, u_bus.serial_valid_out}, 32'd0);
      check("rx_rand_ferr_sticky", {31'd0, ferr}, {31'd0, m_ferr});
    end

    // directed overrun: five frames, room for four
    for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 1'b1);
    repeat (4) tick();
    check("rx_overrun_flag", {31'd0, ovr}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("rx_overrun_data", {24'd0, u_bus.serial_out}, {24'd0, 8'h10 + 8'(i)});
      pop_rx();
    end
    check("rx_overrun_drained", {31'd0, u_bus.serial_valid_out}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
